// File: rtl/i2s_receiver.sv
// I2S capture path: oversamples BCLK/LRCLK/DATA in the system clock domain and
// delivers one left/right sample pair per frame over a valid/ready handshake.
module i2s_receiver #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned MAX_SLOT_BITS = 32
) (
  input  logic             clock,
  input  logic             reset,        // asynchronous, active-low
  input  logic             BCLK,
  input  logic             ADC_LR_CLK,
  input  logic             ADC_DATA,
  input  logic             sample_ready,
  output logic [WIDTH-1:0] sample_left,
  output logic [WIDTH-1:0] sample_right,
  output logic             sample_valid,
  output logic             overrun,
  output logic             frame_error
);

  localparam int unsigned CNT_W = 6;
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_e;

  // Input synchronisers; bclk has a third stage for rising-edge detection
  logic [2:0] bclk_sync_q;
  logic [1:0] ws_sync_q;
  logic [1:0] data_sync_q;

  // Registered edge strobe with the ws/data values seen at that edge
  logic edge_q;
  logic ws_e_q;
  logic data_e_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             ws_prev_q, ws_prev_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             ferr_q, ferr_d;

  logic [WIDTH-1:0] word_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             boundary_c;
  logic             over_c;

  always_comb begin
    // Bits past WIDTH fall off the end of the mask and are ignored
    word_c     = shift_q | ({WIDTH{data_e_q}} & (MSB_ONE >> cnt_q));
    cnt_inc_c  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    boundary_c = (ws_e_q != ws_prev_q);
    over_c     = (32'(cnt_inc_c) > MAX_SLOT_BITS);

    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ws_prev_d = ws_prev_q;
    hold_d    = hold_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    ferr_d    = 1'b0;

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    if (edge_q) begin
      cnt_d   = cnt_inc_c;
      shift_d = word_c;
      if (boundary_c) begin
        cnt_d     = '0;
        shift_d   = '0;
        ws_prev_d = ws_e_q;
      end

      if ((state_q != ALIGN) && over_c) begin
        ferr_d  = 1'b1;
        state_d = ALIGN;
      end else if (boundary_c) begin
        unique case (state_q)
          ALIGN: begin
            if (ws_prev_q && !ws_e_q) begin
              state_d = LEFT;
            end
          end
          LEFT: begin
            hold_d  = word_c;
            state_d = RIGHT;
          end
          RIGHT: begin
            // Publish; acceptance in this same cycle is superseded by the new pair
            left_d    = hold_q;
            right_d   = word_c;
            overrun_d = valid_q && !sample_ready;
            valid_d   = 1'b1;
            state_d   = LEFT;
          end
          default: begin
            state_d = ALIGN;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bclk_sync_q <= '0;
      ws_sync_q   <= '0;
      data_sync_q <= '0;
      edge_q      <= 1'b0;
      ws_e_q      <= 1'b0;
      data_e_q    <= 1'b0;
      state_q     <= ALIGN;
      cnt_q       <= '0;
      shift_q     <= '0;
      ws_prev_q   <= 1'b0;
      hold_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[1:0], BCLK};
      ws_sync_q   <= {ws_sync_q[0], ADC_LR_CLK};
      data_sync_q <= {data_sync_q[0], ADC_DATA};
      edge_q      <= bclk_sync_q[1] & ~bclk_sync_q[2];
      ws_e_q      <= ws_sync_q[1];
      data_e_q    <= data_sync_q[1];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ws_prev_q   <= ws_prev_d;
      hold_q      <= hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      ferr_q      <= ferr_d;
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_error  = ferr_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: table of frames with expected pairs, plus
// overrun, same-cycle accept, framing error, stopped clock and mid-frame reset.
module tb_i2s_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        BCLK;
  logic        ADC_LR_CLK;
  logic        ADC_DATA;
  logic        sample_ready;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        overrun;
  logic        frame_error;

  int checks   = 0;
  int errors   = 0;
  int fe_count = 0;
  int ov_count = 0;

  i2s_receiver #(.WIDTH(16), .MAX_SLOT_BITS(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .BCLK         (BCLK),
    .ADC_LR_CLK   (ADC_LR_CLK),
    .ADC_DATA     (ADC_DATA),
    .sample_ready (sample_ready),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .frame_error  (frame_error)
  );

  always #5 clock = ~clock;

  // Pulse counters, sampled mid-cycle so a multi-cycle pulse counts more than once
  always @(negedge clock) begin
    if (frame_error) fe_count++;
    if (overrun) ov_count++;
  end

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          vw;
    int          nbits;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One BCLK period: fall, present ws/data, rise two clocks later
  task automatic send_bit(input logic ws, input logic d);
    @(negedge clock);
    BCLK       = 1'b0;
    ADC_LR_CLK = ws;
    ADC_DATA   = d;
    repeat (2) @(negedge clock);
    BCLK = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // Bits first..last of a slot; value left-justified, LSB bit carries the next ws
  task automatic send_slot(input logic ch, input logic [31:0] val, input int vw,
                           input int nbits, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      logic b;
      b = (i < vw) ? val[vw-1-i] : 1'b0;
      send_bit((i == nbits - 1) ? ~ch : ch, b);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int vw, input int nbits);
    send_slot(1'b0, l, vw, nbits, 0, nbits - 1);
    send_slot(1'b1, r, vw, nbits, 0, nbits - 1);
  endtask

  // Called right after the right-LSB bit: publish must land on the 4th clock after that rise
  task automatic expect_publish(input string tag, input logic [15:0] el, input logic [15:0] er,
                                input logic prior_valid, input logic exp_ov, input logic ready_now);
    @(posedge clock); #1;
    check({tag, " valid_at_3clk"}, 32'(sample_valid), 32'(prior_valid));
    if (ready_now) sample_ready = 1'b1;
    @(posedge clock); #1;
    sample_ready = 1'b0;
    check({tag, " valid_at_4clk"}, 32'(sample_valid), 32'd1);
    check({tag, " left"}, 32'(sample_left), 32'(el));
    check({tag, " right"}, 32'(sample_right), 32'(er));
    check({tag, " overrun"}, 32'(overrun), 32'(exp_ov));
    @(posedge clock); #1;
    check({tag, " overrun_clears"}, 32'(overrun), 32'd0);
    check({tag, " valid_holds"}, 32'(sample_valid), 32'd1);
  endtask

  task automatic accept(input string tag);
    @(negedge clock);
    sample_ready = 1'b1;
    @(posedge clock); #1;
    sample_ready = 1'b0;
    check({tag, " valid_drops"}, 32'(sample_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{l: 32'h1234,     r: 32'hABCD,     vw: 16, nbits: 32, el: 16'h1234, er: 16'hABCD};
    vecs[1] = '{l: 32'h8001,     r: 32'h7FFF,     vw: 16, nbits: 16, el: 16'h8001, er: 16'h7FFF};
    vecs[2] = '{l: 32'hFFEE55,   r: 32'h123456,   vw: 24, nbits: 24, el: 16'hFFEE, er: 16'h1234};
    vecs[3] = '{l: 32'hABC,      r: 32'h123,      vw: 12, nbits: 12, el: 16'hABC0, er: 16'h1230};
    vecs[4] = '{l: 32'hDEADBEEF, r: 32'h80007FFF, vw: 32, nbits: 32, el: 16'hDEAD, er: 16'h8000};
    vecs[5] = '{l: 32'h0F0F,     r: 32'hF0F0,     vw: 16, nbits: 20, el: 16'h0F0F, er: 16'hF0F0};

    reset        = 1'b0;
    BCLK         = 1'b0;
    ADC_LR_CLK   = 1'b0;
    ADC_DATA     = 1'b0;
    sample_ready = 1'b0;
    repeat (3) @(posedge clock); #1;
    check("rst valid", 32'(sample_valid), 32'd0);
    check("rst left", 32'(sample_left), 32'd0);
    check("rst right", 32'(sample_right), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    check("rst frame_error", 32'(frame_error), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Alignment frame is discarded
    send_frame(32'h1234, 32'hABCD, 16, 32);
    repeat (3) @(posedge clock); #1;
    check("align discard", 32'(sample_valid), 32'd0);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].l, vecs[v].r, vecs[v].vw, vecs[v].nbits);
      expect_publish($sformatf("vec%0d", v), vecs[v].el, vecs[v].er, 1'b0, 1'b0, 1'b0);
      accept($sformatf("vec%0d", v));
    end

    // Two unaccepted frames: second publish overwrites and flags overrun
    send_frame(32'h0001, 32'h0002, 16, 16);
    expect_publish("ovr first", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    send_frame(32'h0003, 32'h0004, 16, 16);
    expect_publish("ovr second", 16'h0003, 16'h0004, 1'b1, 1'b1, 1'b0);
    accept("ovr");

    // Acceptance on the exact publish cycle: new pair loads, no overrun
    send_frame(32'h0005, 32'h0006, 16, 16);
    expect_publish("same first", 16'h0005, 16'h0006, 1'b0, 1'b0, 1'b0);
    send_frame(32'h0007, 32'h0008, 16, 16);
    expect_publish("same second", 16'h0007, 16'h0008, 1'b1, 1'b0, 1'b1);
    accept("same");

    // ws stuck low for 40 BCLKs in LEFT
    check("ferr none yet", 32'(fe_count), 32'd0);
    repeat (40) send_bit(1'b0, 1'b1);
    repeat (4) @(posedge clock); #1;
    check("ferr one pulse", 32'(fe_count), 32'd1);
    check("ferr no publish", 32'(sample_valid), 32'd0);

    send_frame(32'h1111, 32'h2222, 16, 32);
    repeat (3) @(posedge clock); #1;
    check("realign discard", 32'(sample_valid), 32'd0);
    send_frame(32'h1357, 32'h2468, 16, 32);
    expect_publish("realign", 16'h1357, 16'h2468, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a right slot clears outputs without a clock edge
    send_slot(1'b0, 32'h5555, 16, 32, 0, 31);
    send_slot(1'b1, 32'h6666, 16, 32, 0, 15);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("async rst valid", 32'(sample_valid), 32'd0);
    check("async rst left", 32'(sample_left), 32'd0);
    check("async rst right", 32'(sample_right), 32'd0);
    BCLK = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    send_slot(1'b1, 32'h6666, 16, 32, 16, 31);
    send_frame(32'h0A0A, 32'h0B0B, 16, 32);
    expect_publish("post rst", 16'h0A0A, 16'h0B0B, 1'b0, 1'b0, 1'b0);

    // Stopped BCLK: everything holds
    repeat (50) @(posedge clock); #1;
    check("idle valid", 32'(sample_valid), 32'd1);
    check("idle left", 32'(sample_left), 32'h0A0A);
    check("idle right", 32'(sample_right), 32'h0B0B);

    check("total frame_error pulses", 32'(fe_count), 32'd1);
    check("total overrun pulses", 32'(ov_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
